// File: rtl/req_capture.sv
// req_capture: front end for the priority encoder stage.
// The design synchronises asynchronous request lines into clk and detects
// rising edges. Each event is held in a sticky pending vector, which drives
// the encoder input directly. The consumer retires an event by returning its
// index on clr_idx/clr_en. An event that re-triggers while still pending is
// flagged per line in overflow.
// Optional feature: define REQ_DEBOUNCE_EN to place a per-line stable-count
// debouncer between the synchroniser and edge detect.
module req_capture #(
  parameter int unsigned decode_width    = 16,
  parameter int unsigned encode_width    = $clog2(decode_width),
  parameter int unsigned sync_stages     = 2,
  parameter int unsigned debounce_cycles = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [decode_width-1:0] req_in,
  input  logic                    clr_en,
  input  logic [encode_width-1:0] clr_idx,
  input  logic                    ovf_clr,
  output logic [decode_width-1:0] pending,
  output logic                    pending_valid,
  output logic [decode_width-1:0] overflow
);

  logic [sync_stages-1:0][decode_width-1:0] sync_r;
  logic [decode_width-1:0] sync_q;
  logic [decode_width-1:0] edge_src;
  logic [decode_width-1:0] prev_q;
  logic [decode_width-1:0] rise;
  logic [decode_width-1:0] clr_vec;

  // Synchroniser chain per line; stage 0 samples the raw asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[sync_stages-2:0], req_in};
    end
  end

  assign sync_q = sync_r[sync_stages-1];

`ifdef REQ_DEBOUNCE_EN
  localparam int unsigned cnt_w = $clog2(debounce_cycles + 1);

  logic [cnt_w-1:0]        deb_cnt [decode_width];
  logic [decode_width-1:0] deb_q;

  // Per-line debounce. deb_q follows sync_q only after it has differed for
  // debounce_cycles consecutive cycles. The update fires on the edge where the
  // count would reach debounce_cycles, so the added latency is exactly
  // debounce_cycles edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q <= '0;
      for (int unsigned i = 0; i < decode_width; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < decode_width; i++) begin
        if (sync_q[i] == deb_q[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == cnt_w'(debounce_cycles - 1)) begin
          deb_q[i]   <= sync_q[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + cnt_w'(1);
        end
      end
    end
  end

  assign edge_src = deb_q;
`else
  assign edge_src = sync_q;
`endif

  assign rise = edge_src & ~prev_q;

  // Decode the retire strobe into a one-hot vector. An index with no matching
  // line produces no bits, so it changes nothing.
  always_comb begin
    clr_vec = '0;
    for (int unsigned i = 0; i < decode_width; i++) begin
      if (clr_en && (clr_idx == encode_width'(i))) begin
        clr_vec[i] = 1'b1;
      end
    end
  end

  // Edge history. prev resets to 0, so a line held high through reset release
  // is seen as exactly one rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
    end else begin
      prev_q <= edge_src;
    end
  end

  // Sticky pending and overflow. A rise wins over a same-cycle clear of the
  // same bit. In that case the clear is absorbed and no overflow is flagged.
  // A new overflow wins over ovf_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      overflow <= '0;
    end else begin
      pending  <= rise | (pending & ~clr_vec);
      overflow <= (ovf_clr ? '0 : overflow) | (rise & pending & ~clr_vec);
    end
  end

  assign pending_valid = |pending;

endmodule

// File: tb/tb_req_capture.sv
// Directed self-checking bench for req_capture with default parameters.
// The default build covers capture, retire, overflow, set/clear priority and
// asynchronous reset. Built with REQ_DEBOUNCE_EN, it covers debounce filtering
// and latency instead.
module tb_req_capture;

  localparam int unsigned dw = 16;
  localparam int unsigned ew = 4;

  logic          clk;
  logic          rst_n;
  logic [dw-1:0] req_in;
  logic          clr_en;
  logic [ew-1:0] clr_idx;
  logic          ovf_clr;
  logic [dw-1:0] pending;
  logic          pending_valid;
  logic [dw-1:0] overflow;

  int unsigned total;
  int unsigned bad;

  req_capture #(
    .decode_width   (dw),
    .encode_width   (ew),
    .sync_stages    (2),
    .debounce_cycles(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_in       (req_in),
    .clr_en       (clr_en),
    .clr_idx      (clr_idx),
    .ovf_clr      (ovf_clr),
    .pending      (pending),
    .pending_valid(pending_valid),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [dw-1:0] got,
                          input logic [dw-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance n rising edges; return 1 time unit after the last one.
  task automatic tick(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic retire(input logic [ew-1:0] idx);
    clr_en  = 1'b1;
    clr_idx = idx;
    tick(1);
    clr_en  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    req_in  = '0;
    clr_en  = 1'b0;
    clr_idx = '0;
    ovf_clr = 1'b0;
    tick(3);
    check_eq("reset_pending", pending, 16'h0000);
    check_eq("reset_overflow", overflow, 16'h0000);
    check_eq("reset_valid", {15'b0, pending_valid}, 16'h0000);
    rst_n = 1'b1;
    tick(3);

`ifndef REQ_DEBOUNCE_EN
    // Single capture: line 5, three edges of latency.
    req_in[5] = 1'b1;
    tick(2);
    check_eq("lat_edge2_pending", pending, 16'h0000);
    tick(1);
    check_eq("lat_edge3_pending", pending, 16'h0020);
    check_eq("lat_edge3_valid", {15'b0, pending_valid}, 16'h0001);
    tick(7);
    req_in[5] = 1'b0;
    tick(4);
    check_eq("sticky_pending", pending, 16'h0020);
    check_eq("sticky_overflow", overflow, 16'h0000);
    retire(4'd5);
    check_eq("retire5", pending, 16'h0000);
    retire(4'd9);
    check_eq("clear_zero_bit", pending, 16'h0000);

    // Two lines together, then retire each.
    req_in = 16'h1008;
    tick(3);
    check_eq("two_lines", pending, 16'h1008);
    retire(4'd12);
    check_eq("retire12", pending, 16'h0008);
    retire(4'd3);
    check_eq("retire3", pending, 16'h0000);
    check_eq("retire3_valid", {15'b0, pending_valid}, 16'h0000);
    req_in = '0;
    tick(4);

    // Lost event on line 7: two pulses with rises 6 cycles apart.
    req_in[7] = 1'b1;
    tick(2);
    req_in[7] = 1'b0;
    tick(4);
    req_in[7] = 1'b1;
    tick(2);
    check_eq("ovf_before", overflow, 16'h0000);
    req_in[7] = 1'b0;
    tick(1);
    check_eq("ovf_set", overflow, 16'h0080);
    check_eq("ovf_pending", pending, 16'h0080);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check_eq("ovf_cleared", overflow, 16'h0000);
    check_eq("ovf_clr_keeps_pending", pending, 16'h0080);
    retire(4'd7);
    tick(3);

    // Rise on line 2 in the same cycle as a clear of line 2.
    req_in[2] = 1'b1;
    tick(2);
    req_in[2] = 1'b0;
    tick(4);
    check_eq("line2_armed", pending, 16'h0004);
    req_in[2] = 1'b1;
    tick(2);
    clr_en  = 1'b1;
    clr_idx = 4'd2;
    tick(1);
    clr_en  = 1'b0;
    check_eq("set_beats_clr_pending", pending, 16'h0004);
    check_eq("set_beats_clr_overflow", overflow, 16'h0000);

    // A new overflow coincides with ovf_clr: the set wins.
    req_in[2] = 1'b0;
    tick(4);
    req_in[2] = 1'b1;
    tick(2);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check_eq("ovf_set_beats_clr", overflow, 16'h0004);
    req_in[2] = 1'b0;

    // All lines held high through reset release.
    rst_n = 1'b0;
    #2;
    check_eq("async_rst_overflow", overflow, 16'h0000);
    check_eq("async_rst_pending", pending, 16'h0000);
    req_in = 16'hFFFF;
    tick(1);
    rst_n = 1'b1;
    tick(2);
    check_eq("all_edge2", pending, 16'h0000);
    tick(1);
    check_eq("all_edge3", pending, 16'hFFFF);
    retire(4'd15);
    check_eq("retire15", pending, 16'h7FFF);
    tick(3);
    check_eq("held_no_retrigger", overflow, 16'h0000);
    check_eq("held_pending", pending, 16'h7FFF);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midcycle_rst_pending", pending, 16'h0000);
    check_eq("midcycle_rst_valid", {15'b0, pending_valid}, 16'h0000);
    check_eq("midcycle_rst_overflow", overflow, 16'h0000);
`else
    // A 2-cycle glitch on line 0 is rejected.
    req_in[0] = 1'b1;
    tick(2);
    req_in[0] = 1'b0;
    tick(12);
    check_eq("deb_glitch", pending, 16'h0000);
    // A 10-cycle pulse is captured 7 edges after the rise.
    req_in[0] = 1'b1;
    tick(6);
    check_eq("deb_edge6", pending, 16'h0000);
    tick(1);
    check_eq("deb_edge7", pending, 16'h0001);
    tick(3);
    req_in[0] = 1'b0;
    tick(12);
    check_eq("deb_sticky", pending, 16'h0001);
    check_eq("deb_overflow", overflow, 16'h0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/req_capture.md
Name: req_capture

Overview:
- Upstream front end for the priority encoder stage.
- Samples decode_width asynchronous request lines and synchronises them into clk.
- Detects rising edges and holds each event in a sticky pending vector. That vector drives the encoder's "in" bus directly.
- The consumer reads the encoder's index and returns it on clr_idx/clr_en to retire that event. Lost events (re-trigger while still pending) are flagged per line.

Parameters:
- decode_width, 16, number of request lines; equals the encoder's decode_width.
- encode_width, $clog2(decode_width), index width; equals the encoder's encode_width.
- sync_stages, 2, flops in each synchroniser chain; legal range ≥2.
- debounce_cycles, 4, stable-sample count required per line; used only when REQ_DEBOUNCE_EN is defined; legal range ≥1.

Ports:
- clk  in  1  single system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset; release is synchronous to clk.
- req_in  in  decode_width  raw asynchronous request lines, level-high active.
- clr_en  in  1  retire strobe, one cycle per retirement.
- clr_idx  in  encode_width  index of the line to retire, qualified by clr_en.
- ovf_clr  in  1  clears the whole overflow vector.
- pending  out  decode_width  sticky event vector; drives encoder "in".
- pending_valid  out  1  OR-reduction of pending.
- overflow  out  decode_width  sticky per-line lost-event flags.

Behaviour:
- Reset (rst_n low, asynchronous): synchroniser flops, prev register, pending and overflow go to 0; pending_valid goes to 0. Debounce counters/state also go to 0 when that feature is compiled in.
- A line held high through reset release is seen as a rising edge, because prev resets to 0. It produces exactly one event.
- Synchroniser: per line, a sync_stages-deep flop chain. sync_q is the last stage.
- Edge detect: rise[i] = sync_q[i] & ~prev_q[i]. prev_q loads sync_q every cycle.
- Latency: if req_in[i] rises before edge N, pending[i] is 1 after edge N+sync_stages. This is 3 edges at the defaults.
- Pending update per bit, every cycle:
  - rise=1: pending set to 1. Set wins over a same-cycle clear of the same bit.
  - rise=0 and clr_en=1 and clr_idx==i: pending cleared to 0.
  - otherwise: pending holds.
- Overflow per bit: set when rise[i]=1 and pending[i]=1, unless a clear for i occurs in the same cycle. In that case the clear is absorbed, pending stays 1 and overflow is not set.
- Overflow is cleared only by ovf_clr. If ovf_clr coincides with a new overflow condition, the set wins.
- clr_idx ≥ decode_width: ignored, with no state change.
- clr_en on a bit already 0: no effect.
- pending_valid: combinational OR of the pending register, so it is glitch-free and valid in the same cycle as pending.
- Falling edges generate nothing. A line pulse shorter than one clk period may be missed; that is acceptable.
- No internal FSM beyond the per-line synchroniser, edge and sticky registers. Each line is independent.

Optional Feature:
- Macro: REQ_DEBOUNCE_EN.
- Defined:
  - Each line gets a counter of width $clog2(debounce_cycles+1) and a deb_q state bit, placed between sync_q and edge detect.
  - The counter resets to 0 whenever sync_q[i]==deb_q[i]. Otherwise it increments.
  - When the count reaches debounce_cycles, deb_q[i] takes sync_q[i] and the counter clears.
  - Edge detect uses deb_q in place of sync_q.
  - Added latency is debounce_cycles edges. Any sync_q glitch shorter than debounce_cycles cycles is rejected.
- Undefined: no counters or deb_q; behaviour exactly as above.

Test Plan:
- Reset, then raise req_in[5] for 10 cycles → pending=16'h0020 and pending_valid=1 three edges after the rise. The bit stays set after req_in falls; overflow=0.
- Raise req_in[3] and req_in[12] together; after capture pulse clr_en with clr_idx=12 → pending goes 16'h1008 → 16'h0008. A second clr_en with clr_idx=3 → pending=0, pending_valid=0.
- Pulse req_in[7] twice, 6 cycles apart, with no clear → pending[7]=1 and overflow=16'h0080. Then ovf_clr=1 → overflow=0 while pending[7] stays 1.
- Arrange a rise on line 2 in the same cycle as clr_en with clr_idx=2, while pending[2]=1 → pending[2] stays 1 and overflow[2]=0.
- Hold req_in=16'hFFFF through reset and release rst_n → pending=16'hFFFF after 3 edges. clr_en with clr_idx=4'd15 then clears only bit 15. Asserting rst_n=0 mid-cycle zeroes all outputs immediately, without waiting for a clock edge.
- With REQ_DEBOUNCE_EN and debounce_cycles=4: a 2-cycle pulse on line 0 leaves pending=0. A 10-cycle pulse sets pending[0] 7 edges after the rise.
